// File: rtl/axis_pkt_gen_pkg.sv
// axis_pkt_gen_pkg: shared FSM state type, beat geometry constants and length helpers for axis_pkt_gen
package axis_pkt_gen_pkg;
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;
    localparam int BYTES_PER_BEAT = 32;
    localparam int LANES = 8;
    // Byte mask of a last beat holding rem valid bytes; rem == 0 means a full beat.
    function automatic logic [31:0] keep_from_len(input logic [4:0] rem);
        return (rem == 5'd0) ? '1 : (32'd1 << rem) - 32'd1;
    endfunction
    function automatic logic [31:0] beats_from_len(input logic [31:0] len);
        return (len + 32'(BYTES_PER_BEAT - 1)) / 32'(BYTES_PER_BEAT);
    endfunction
endpackage

// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI4-Stream packet generator with programmable length, count and inter-packet gap
// Ports: ACLK/ARESETN clock and async active-low reset; START/STOP run control;
//        PKT_LEN/PKT_CNT/IFG run configuration latched at START; BUSY/DONE run status;
//        M_AXIS_* stream master; TX_PKTS/TX_BYTES statistics.
// Build option: define AXIS_PKT_GEN_STATS_EN to enable TX_PKTS/TX_BYTES, otherwise they read 0.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int KEEP_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              START,
    input  logic              STOP,
    input  logic [LEN_W-1:0]  PKT_LEN,
    input  logic [31:0]       PKT_CNT,
    input  logic [7:0]        IFG,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic              M_AXIS_TLAST,
    output logic [KEEP_W-1:0] M_AXIS_TKEEP,
    output logic [31:0]       TX_PKTS,
    output logic [47:0]       TX_BYTES
);
    localparam int B_W = LEN_W - 5;
    state_e            state_q;
    logic [B_W-1:0]    b_q, last_b_q;
    logic [KEEP_W-1:0] keep_last_q;
    logic [31:0]       cnt_q, seq_q;
    logic [7:0]        ifg_q, gap_q;
    logic              stop_q, busy_q, done_q;
    logic [LEN_W-1:0]  len_eff;
    logic [DATA_W-1:0] pat;
    logic              send, last, acc, fin;

    assign len_eff = (PKT_LEN == '0) ? LEN_W'(1) : PKT_LEN;
    assign send    = state_q == SEND;
    assign last    = b_q == last_b_q;
    assign acc     = send & M_AXIS_TREADY;
    // STOP in the same cycle as the last handshake still ends the run after this packet.
    assign fin     = (cnt_q != 32'd0 && seq_q + 32'd1 == cnt_q) || stop_q || STOP;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign pat[i*32 +: 32] = {seq_q[15:0], 16'({b_q, 3'b000}) + 16'(i)};
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            b_q         <= '0;
            last_b_q    <= '0;
            keep_last_q <= '0;
            cnt_q       <= '0;
            seq_q       <= '0;
            ifg_q       <= '0;
            gap_q       <= '0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (START) begin
                    state_q     <= SEND;
                    last_b_q    <= B_W'(beats_from_len(32'(len_eff)) - 32'd1);
                    keep_last_q <= KEEP_W'(keep_from_len(len_eff[4:0]));
                    cnt_q       <= PKT_CNT;
                    ifg_q       <= IFG;
                    seq_q       <= '0;
                    b_q         <= '0;
                    stop_q      <= 1'b0;
                    busy_q      <= 1'b1;
                end
                SEND: begin
                    if (STOP) stop_q <= 1'b1;
                    if (acc) begin
                        b_q <= last ? '0 : b_q + 1'b1;
                        if (last) begin
                            seq_q <= seq_q + 32'd1;
                            if (fin) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else if (ifg_q != 8'd0) begin
                                state_q <= GAP;
                                gap_q   <= ifg_q;
                            end
                        end
                    end
                end
                GAP: begin
                    if (STOP) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (gap_q == 8'd1) begin
                        state_q <= SEND;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are forced to zero outside SEND so reset and idle present an all-zero bus.
    assign M_AXIS_TVALID = send;
    assign M_AXIS_TLAST  = send & last;
    assign M_AXIS_TKEEP  = send ? (last ? keep_last_q : '1) : '0;
    assign M_AXIS_TDATA  = send ? pat : '0;
    assign BUSY          = busy_q;
    assign DONE          = done_q;

`ifdef AXIS_PKT_GEN_STATS_EN
    logic [31:0] pkts_q;
    logic [47:0] bytes_q;
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pkts_q  <= '0;
            bytes_q <= '0;
        end else if (state_q == IDLE && START) begin
            pkts_q  <= '0;
            bytes_q <= '0;
        end else if (acc) begin
            pkts_q  <= pkts_q + {31'd0, M_AXIS_TLAST};
            bytes_q <= bytes_q + 48'($countones(M_AXIS_TKEEP));
        end
    end
    assign TX_PKTS  = pkts_q;
    assign TX_BYTES = bytes_q;
`else
    assign TX_PKTS  = '0;
    assign TX_BYTES = '0;
`endif
endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb_axis_pkt_gen: scoreboard bench for axis_pkt_gen
module tb_axis_pkt_gen;
    localparam int DATA_W = 256;
    localparam int KEEP_W = 32;
    localparam int LEN_W  = 16;

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic              START = 1'b0;
    logic              STOP = 1'b0;
    logic [LEN_W-1:0]  PKT_LEN = '0;
    logic [31:0]       PKT_CNT = '0;
    logic [7:0]        IFG = '0;
    logic              M_AXIS_TREADY = 1'b1;
    logic              BUSY, DONE, M_AXIS_TVALID, M_AXIS_TLAST;
    logic [DATA_W-1:0] M_AXIS_TDATA;
    logic [KEEP_W-1:0] M_AXIS_TKEEP;
    logic [31:0]       TX_PKTS;
    logic [47:0]       TX_BYTES;

    axis_pkt_gen #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .LEN_W(LEN_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .START(START), .STOP(STOP),
        .PKT_LEN(PKT_LEN), .PKT_CNT(PKT_CNT), .IFG(IFG),
        .BUSY(BUSY), .DONE(DONE),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TKEEP(M_AXIS_TKEEP), .TX_PKTS(TX_PKTS), .TX_BYTES(TX_BYTES)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  k;
        logic         l;
    } beat_t;

    beat_t q[$];
    int gaps[$];
    int checks = 0;
    int passes = 0;

    function automatic beat_t mk_beat(int seq, int b, int len, int nb);
        beat_t e;
        int r;
        for (int i = 0; i < 8; i++) e.d[i*32 +: 32] = {seq[15:0], 16'(b * 8 + i)};
        e.l = (b == nb - 1);
        r = len % 32;
        e.k = !e.l ? '1 : (r == 0 ? '1 : (32'd1 << r) - 32'd1);
        return e;
    endfunction

    task automatic push_pkts(input int first_seq, input int n, input int len);
        int l, nb;
        l = (len == 0) ? 1 : len;
        nb = (l + 31) / 32;
        for (int p = 0; p < n; p++)
            for (int b = 0; b < nb; b++) q.push_back(mk_beat(first_seq + p, b, l, nb));
    endtask

    task automatic start_run(input int len, input int cnt, input int ifg);
        @(negedge ACLK);
        PKT_LEN = LEN_W'(len);
        PKT_CNT = cnt;
        IFG = 8'(ifg);
        START = 1'b1;
    endtask

    // Drives TREADY/STOP each falling edge, checks accepted beats against the scoreboard,
    // records idle gaps between packets and stops at DONE, abort or timeout.
    task automatic run(input string nm, input int stop_pkt, input int stop_beat, input bit rnd,
                       input int abort_beat, input bit glitch);
        int cyc = 0, pkt_i = 0, beat_i = 0, last_acc = -10, gap_cnt = 0;
        bit in_gap = 0, stalled = 0, stop_sent = 0, tr, bad;
        logic [255:0] hd;
        logic [31:0] hk;
        logic hl;
        beat_t e;
        gaps.delete();
        forever begin
            @(negedge ACLK);
            cyc++;
            START = 1'b0;
            STOP = 1'b0;
            if (glitch && cyc == 3) begin
                START = 1'b1;
                PKT_LEN = 16'd7;
                PKT_CNT = 32'd1;
                IFG = 8'd0;
            end
            if (cyc == 1) begin
                checks++;
                if (M_AXIS_TVALID !== 1'b1 || BUSY !== 1'b1)
                    $display("FAIL %s latency: tvalid=%b busy=%b, want 1 1", nm, M_AXIS_TVALID, BUSY);
                else passes++;
            end
            if (stalled) begin
                checks++;
                if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== hd || M_AXIS_TKEEP !== hk || M_AXIS_TLAST !== hl)
                    $display("FAIL %s stable: tvalid=%b d=%h k=%h l=%b, want 1 d=%h k=%h l=%b",
                             nm, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, hd, hk, hl);
                else passes++;
            end
            if (DONE === 1'b1) begin
                checks++;
                if (BUSY !== 1'b0 || M_AXIS_TVALID !== 1'b0)
                    $display("FAIL %s done_state: busy=%b tvalid=%b, want 0 0", nm, BUSY, M_AXIS_TVALID);
                else passes++;
                if (stop_beat >= 0) begin
                    checks++;
                    if (cyc != last_acc + 1)
                        $display("FAIL %s done_timing: done at cycle %0d, want %0d", nm, cyc, last_acc + 1);
                    else passes++;
                end
                break;
            end
            if (cyc > 4000) begin
                checks++;
                $display("FAIL %s timeout: no DONE after %0d cycles, want DONE", nm, cyc);
                break;
            end
            if (M_AXIS_TVALID === 1'b1) begin
                if (in_gap) begin
                    gaps.push_back(gap_cnt);
                    in_gap = 0;
                end
            end else if (in_gap) gap_cnt++;
            if (abort_beat >= 0 && beat_i == abort_beat && M_AXIS_TVALID === 1'b1) begin
                ARESETN = 1'b0;
                #1;
                checks++;
                if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0 || M_AXIS_TDATA !== '0 ||
                    M_AXIS_TKEEP !== '0 || BUSY !== 1'b0 || DONE !== 1'b0)
                    $display("FAIL %s abort_zero: tvalid=%b tlast=%b d=%h k=%h busy=%b done=%b, want all 0",
                             nm, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, M_AXIS_TKEEP, BUSY, DONE);
                else passes++;
                q.delete();
                break;
            end
            if (stop_pkt >= 0 && pkt_i == stop_pkt && !stop_sent &&
                ((stop_beat >= 0 && beat_i == stop_beat && M_AXIS_TVALID === 1'b1) ||
                 (stop_beat < 0 && in_gap && gap_cnt == 2))) begin
                STOP = 1'b1;
                stop_sent = 1;
            end
            tr = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            M_AXIS_TREADY = tr;
            if (M_AXIS_TVALID === 1'b1 && tr) begin
                stalled = 0;
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL %s extra_beat: pkt %0d beat %0d d=%h, want no beat", nm, pkt_i, beat_i, M_AXIS_TDATA);
                end else begin
                    e = q.pop_front();
                    if (M_AXIS_TDATA !== e.d || M_AXIS_TKEEP !== e.k || M_AXIS_TLAST !== e.l)
                        $display("FAIL %s beat p%0d b%0d: got d=%h k=%h l=%b, want d=%h k=%h l=%b",
                                 nm, pkt_i, beat_i, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, e.d, e.k, e.l);
                    else passes++;
                end
                if (M_AXIS_TLAST === 1'b1) begin
                    pkt_i++;
                    beat_i = 0;
                    in_gap = 1;
                    gap_cnt = 0;
                    last_acc = cyc;
                end else beat_i++;
            end else if (M_AXIS_TVALID === 1'b1) begin
                stalled = 1;
                hd = M_AXIS_TDATA;
                hk = M_AXIS_TKEEP;
                hl = M_AXIS_TLAST;
            end
        end
        M_AXIS_TREADY = 1'b1;
        STOP = 1'b0;
        START = 1'b0;
        if (abort_beat < 0) begin
            checks++;
            if (q.size() != 0) $display("FAIL %s sb_empty: %0d beats missing, want 0", nm, q.size());
            else passes++;
            q.delete();
            bad = 0;
            repeat (3) begin
                @(negedge ACLK);
                if (M_AXIS_TVALID !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) bad = 1;
            end
            checks++;
            if (bad) $display("FAIL %s quiet: activity after DONE, want idle", nm);
            else passes++;
        end
    endtask

    task automatic test_reset();
        @(negedge ACLK);
        checks++;
        if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0)
            $display("FAIL reset ctl: tvalid=%b tlast=%b busy=%b done=%b, want 0", M_AXIS_TVALID, M_AXIS_TLAST, BUSY, DONE);
        else passes++;
        checks++;
        if (M_AXIS_TDATA !== '0 || M_AXIS_TKEEP !== '0)
            $display("FAIL reset bus: d=%h k=%h, want 0", M_AXIS_TDATA, M_AXIS_TKEEP);
        else passes++;
        checks++;
        if (TX_PKTS !== '0 || TX_BYTES !== '0)
            $display("FAIL reset stats: pkts=%0d bytes=%0d, want 0", TX_PKTS, TX_BYTES);
        else passes++;
        @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    task automatic test_single();
        push_pkts(0, 1, 64);
        start_run(64, 1, 0);
        run("single", -1, 0, 0, -1, 0);
    endtask

    task automatic test_zero_len();
        push_pkts(0, 1, 0);
        start_run(0, 1, 0);
        run("zero_len", -1, 0, 0, -1, 0);
    endtask

    task automatic test_gap();
        push_pkts(0, 3, 33);
        start_run(33, 3, 4);
        run("gap", -1, 0, 0, -1, 1);
        checks++;
        if (gaps.size() != 2) $display("FAIL gap count: %0d gaps, want 2", gaps.size());
        else passes++;
        foreach (gaps[i]) begin
            checks++;
            if (gaps[i] != 4) $display("FAIL gap len%0d: %0d idle cycles, want 4", i, gaps[i]);
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        push_pkts(0, 2, 100);
        start_run(100, 2, 1);
        run("backpressure", -1, 0, 1, -1, 0);
    endtask

    task automatic test_stop();
        int s = 0;
        push_pkts(0, 5, 96);
        start_run(96, 0, 0);
        run("stop", 4, 1, 0, -1, 0);
        foreach (gaps[i]) s += gaps[i];
        checks++;
        if (gaps.size() != 4 || s != 0)
            $display("FAIL stop b2b: %0d gaps totalling %0d, want 4 totalling 0", gaps.size(), s);
        else passes++;
    endtask

    task automatic test_stop_gap();
        push_pkts(0, 2, 32);
        start_run(32, 0, 5);
        run("stop_gap", 2, -1, 0, -1, 0);
        checks++;
        if (gaps.size() != 1 || gaps[0] != 5)
            $display("FAIL stop_gap gaps: size %0d first %0d, want 1 and 5", gaps.size(), gaps.size() > 0 ? gaps[0] : -1);
        else passes++;
    endtask

    task automatic test_reset_mid();
        push_pkts(0, 1, 320);
        start_run(320, 1, 0);
        run("reset_mid", -1, 0, 0, 3, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        push_pkts(0, 1, 64);
        start_run(64, 1, 0);
        run("after_reset", -1, 0, 0, -1, 0);
    endtask

    task automatic test_stats();
        logic [31:0] ep;
        logic [47:0] eb;
`ifdef AXIS_PKT_GEN_STATS_EN
        ep = 32'd4;
        eb = 48'd260;
`else
        ep = 32'd0;
        eb = 48'd0;
`endif
        push_pkts(0, 4, 65);
        start_run(65, 4, 0);
        run("stats", -1, 0, 1, -1, 0);
        checks++;
        if (TX_PKTS !== ep || TX_BYTES !== eb)
            $display("FAIL stats: pkts=%0d bytes=%0d, want %0d %0d", TX_PKTS, TX_BYTES, ep, eb);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_gap();
        test_backpressure();
        test_stop();
        test_stop_gap();
        test_reset_mid();
        test_stats();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
